// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time and
// fills a stallable IF/ID register; handles EX redirects, misaligned and timeout faults.
module fetch_controller #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          IMEM_ADDR_W  = 9,
  parameter int          TIMEOUT      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   imem_req,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic                   imem_ready,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            pc_out,
  output logic                   if_valid,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_instr,
  output logic                   fault,
  output logic [1:0]             fault_code
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FAULT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] to_cnt;
  logic          misalign, xfer, waiting, to_hit, redir_ok;

  assign misalign  = redirect_pc[1:0] != 2'b00;
  assign redir_ok  = redirect && (state != S_FAULT);
  assign imem_addr = pc_out[IMEM_ADDR_W-1:0];
  assign xfer      = imem_req & imem_ready;
  assign waiting   = imem_req & ~imem_ready;
  // Fault on the edge that would push the wait count to TIMEOUT.
  assign to_hit    = waiting && (to_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      S_IDLE: begin
        state_nxt = (redirect && misalign) ? S_FAULT : S_FETCH;
      end
      S_FETCH: begin
        imem_req = !(if_valid && stall);
        if (redirect)    state_nxt = misalign ? S_FAULT : S_FETCH;
        else if (to_hit) state_nxt = S_FAULT;
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_out     <= RESET_VECTOR;
      if_valid   <= 1'b0;
      if_pc      <= '0;
      if_instr   <= '0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      to_cnt     <= '0;
    end else if (redir_ok) begin
      // Redirect wins over transfer, stall and timeout; same-cycle data is dropped.
      if_valid <= 1'b0;
      pc_out   <= redirect_pc;
      to_cnt   <= '0;
      if (misalign) begin
        fault      <= 1'b1;
        fault_code <= 2'b01;
      end
    end else if (state == S_FETCH) begin
      if (to_hit) begin
        fault      <= 1'b1;
        fault_code <= 2'b10;
        if_valid   <= 1'b0;
        to_cnt     <= '0;
      end else if (xfer) begin
        if_valid <= 1'b1;
        if_pc    <= pc_out;
        if_instr <= imem_rdata;
        pc_out   <= pc_out + 32'd4;
        to_cnt   <= '0;
      end else begin
        if (if_valid && !stall) if_valid <= 1'b0;
        to_cnt <= waiting ? to_cnt + 1'b1 : '0;
      end
    end
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Instruction-fetch sequencer for the RISC-V core.
- Owns the program counter and issues one request at a time to instruction memory using a request/ready handshake.
- Delivers {pc, instruction} into a single IF/ID output register that downstream can stall.
- Applies branch/jump redirects from EX and detects misaligned-target and memory-timeout faults.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
IMEM_ADDR_W, 9, width of the byte address driven to instruction memory; the low IMEM_ADDR_W bits of PC.
TIMEOUT, 16, max cycles imem_req may stay high without imem_ready before a timeout fault.

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst  input  1  asynchronous active-low reset.
stall  input  1  downstream cannot accept; holds IF/ID when if_valid=1.
redirect  input  1  branch/jump taken in EX; highest priority.
redirect_pc  input  32  target PC for redirect.
imem_req  output  1  fetch request; held until accepted.
imem_addr  output  IMEM_ADDR_W  byte address; pc[IMEM_ADDR_W-1:0].
imem_ready  input  1  memory data valid this cycle; transfer = imem_req & imem_ready at the edge.
imem_rdata  input  32  instruction word, valid when imem_ready=1.
pc_out  output  32  current fetch PC.
if_valid  output  1  IF/ID register holds a valid instruction.
if_pc  output  32  PC of the instruction in IF/ID.
if_instr  output  32  instruction in IF/ID.
fault  output  1  sticky fault flag.
fault_code  output  2  00 none, 01 misaligned redirect, 10 imem timeout.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_out=RESET_VECTOR; if_valid=0; if_pc=0; if_instr=0.
  - imem_req=0; fault=0; fault_code=00; timeout counter=0; state=IDLE.
- States: IDLE, FETCH, FAULT.
  - IDLE: exactly one cycle after reset release, imem_req=0; then FETCH.
  - FETCH: imem_req = !(if_valid & stall). imem_addr follows pc_out combinationally.
  - FAULT: imem_req=0 and if_valid=0. Left only by reset.
- Slot free: !if_valid | !stall.
- Transfer, in FETCH with no redirect, when imem_req & imem_ready at an edge:
  - if_valid<=1, if_pc<=pc_out, if_instr<=imem_rdata, pc_out<=pc_out+4.
  - Throughput is 1 instruction/cycle when imem_ready is tied high.
- Consume: at an edge with if_valid=1, stall=0 and no transfer, if_valid<=0.
- Stall: with if_valid=1 and stall=1, if_pc, if_instr and pc_out hold and imem_req=0. With if_valid=0, stall is ignored and fetch continues.
- Redirect (any state except FAULT), at that edge:
  - if_valid<=0, pc_out<=redirect_pc, timeout counter<=0.
  - Any same-cycle imem_ready data is discarded, and the request is re-issued at the new address next cycle.
  - Redirect overrides transfer, stall and timeout in the same cycle.
- Misaligned redirect (redirect_pc[1:0]!=0): FAULT, fault=1, fault_code=01; pc_out<=redirect_pc for debug.
- Timeout:
  - Counter increments each cycle imem_req=1 & imem_ready=0; clears on transfer, on redirect, or when imem_req=0.
  - When the counter reaches TIMEOUT: FAULT, fault=1, fault_code=10, pc_out unchanged.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- imem_addr is a truncation; aliasing beyond 2^IMEM_ADDR_W bytes is permitted.
- Reset asserted mid-wait or mid-stall returns all state to reset values immediately; no handshake completes.

Test Plan:
- Hold rst=0 for 2 cycles, then release → pc_out=0, if_valid=0, imem_req=0 during reset and the first cycle after; second cycle imem_req=1, imem_addr=0.
- imem_ready=1, stall=0, memory preloaded → if_pc=0,4,8,12 on consecutive cycles; if_instr matches the memory words at those addresses.
- After if_pc=8, hold stall=1 for 3 cycles → if_pc=8, if_valid=1, imem_req=0, pc_out=12 held; release → next if_pc=12.
- imem_ready=0 at pc=0x10, then redirect=1 with redirect_pc=0x40 → next cycle if_valid=0, imem_addr=0x40; after ready, if_pc=0x40, pc_out=0x44.
- redirect_pc=0x42 → fault=1, fault_code=01, imem_req=0, if_valid=0 until rst.
- imem_ready held 0 for 16 cycles → fault_code=10, pc_out unchanged; pulse rst=0 → fault clears, fetch restarts at RESET_VECTOR.
